// File: rtl/progmem_multiport.sv
// Multi-port program memory: N independent instruction-fetch ports plus a
// byte-serial loader that writes programs and holds the cores off while loading.
module progmem_multiport #(
    parameter int INST_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int N_PORTS = 2,
    parameter int REG_OUT = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_PORTS*ADDR_W-1:0]   progmem_addr,
    output logic [N_PORTS*INST_W-1:0]   progmem_data,
    output logic                        core_en,
    input  logic                        load_start,
    input  logic                        load_valid,
    input  logic [7:0]                  load_byte,
    input  logic                        load_last,
    output logic                        load_ready,
    output logic                        loading,
    output logic [ADDR_W:0]             load_count,
    output logic                        load_err
);

    localparam int LANES = INST_W / 8;
    localparam int BI_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int WORDS = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic {IDLE, LOAD} state_t;

    state_t              state;
    state_t              state_nx;
    logic [INST_W-1:0]   mem [WORDS];
    logic [ADDR_W:0]     wr_ptr;
    logic [BI_W-1:0]     bi;
    logic [INST_W-1:0]   asm_q;
    logic [INST_W-1:0]   wr_word;
    logic                accept;
    logic                word_done;
    logic                full;
    logic                mem_we;

    assign load_ready = (state == LOAD);
    assign loading    = (state == LOAD);
    assign load_count = wr_ptr;

    // load_start wins over a byte offered in the same cycle
    assign accept    = load_valid && load_ready && !load_start;
    assign word_done = accept && ((bi == BI_W'(LANES - 1)) || load_last);
    assign full      = (wr_ptr == DEPTH);
    assign mem_we    = word_done && !full && !rst;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (load_start) state_nx = LOAD;
            LOAD: begin
                if (load_start)
                    state_nx = LOAD;
                else if (accept && load_last)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Lanes below bi come from the assembly buffer, lanes above are zero
    always_comb begin
        wr_word = '0;
        for (int l = 0; l < LANES; l++) begin
            if (BI_W'(l) < bi)
                wr_word[l*8 +: 8] = asm_q[l*8 +: 8];
            else if (BI_W'(l) == bi)
                wr_word[l*8 +: 8] = load_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            core_en <= 1'b0;
            wr_ptr  <= '0;
            bi      <= '0;
            asm_q   <= '0;
            load_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (load_start) begin
                wr_ptr   <= '0;
                bi       <= '0;
                load_err <= 1'b0;
                core_en  <= 1'b0;
            end else if (accept) begin
                asm_q[int'(bi)*8 +: 8] <= load_byte;
                if (word_done) begin
                    bi <= '0;
                    if (full)
                        load_err <= 1'b1;
                    else
                        wr_ptr <= wr_ptr + 1'b1;
                end else begin
                    bi <= bi + 1'b1;
                end
                if (load_last)
                    core_en <= 1'b1;
            end
        end
    end

    // Array is deliberately not cleared by rst
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[wr_ptr[ADDR_W-1:0]] <= wr_word;
    end

    for (genvar p = 0; p < N_PORTS; p++) begin : g_port
        logic [ADDR_W-1:0] addr;
        assign addr = progmem_addr[p*ADDR_W +: ADDR_W];
        if (REG_OUT != 0) begin : g_reg
            logic [INST_W-1:0] q;
            always_ff @(posedge clk) begin
                if (rst)
                    q <= '0;
                else
                    q <= mem[addr];
            end
            assign progmem_data[p*INST_W +: INST_W] = q;
        end else begin : g_comb
            assign progmem_data[p*INST_W +: INST_W] = mem[addr];
        end
    end

endmodule

// File: tb/tb_progmem_multiport.sv
// Bench for progmem_multiport: a combinational 256-word instance and a
// registered 4-word instance share one load stream, checked against a model.
module tb_progmem_multiport;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        load_start;
    logic        load_valid;
    logic        load_last;
    logic [7:0]  load_byte;
    logic [15:0] addr0;
    logic [3:0]  addr1;
    logic [63:0] data0;
    logic [63:0] data1;
    logic        en0, en1, rdy0, rdy1, ld0, ld1, err0, err1;
    logic [8:0]  cnt0;
    logic [2:0]  cnt1;

    progmem_multiport #(.INST_W(32), .ADDR_W(8), .N_PORTS(2), .REG_OUT(0)) dut0 (
        .clk(clk), .rst(rst),
        .progmem_addr(addr0), .progmem_data(data0), .core_en(en0),
        .load_start(load_start), .load_valid(load_valid),
        .load_byte(load_byte), .load_last(load_last),
        .load_ready(rdy0), .loading(ld0), .load_count(cnt0), .load_err(err0)
    );

    progmem_multiport #(.INST_W(32), .ADDR_W(2), .N_PORTS(2), .REG_OUT(1)) dut1 (
        .clk(clk), .rst(rst),
        .progmem_addr(addr1), .progmem_data(data1), .core_en(en1),
        .load_start(load_start), .load_valid(load_valid),
        .load_byte(load_byte), .load_last(load_last),
        .load_ready(rdy1), .loading(ld1), .load_count(cnt1), .load_err(err1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: index 0 is the 256-word instance, index 1 the 4-word one
    logic [31:0] mmem [2][256];
    bit          mk   [2][256];
    bit          m_load [2];
    bit          m_en   [2];
    bit          m_err  [2];
    int          m_ptr  [2];
    int          m_n    [2];
    logic [7:0]  m_b    [2][4];
    logic [31:0] m_rd   [2];
    bit          m_rdk  [2];
    logic [31:0] m_w;
    bit          started = 1'b0;

    function automatic int dep(input int d);
        return (d == 0) ? 256 : 4;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            started = 1'b1;
            for (int d = 0; d < 2; d++) begin
                m_load[d] = 1'b0;
                m_en[d]   = 1'b0;
                m_err[d]  = 1'b0;
                m_ptr[d]  = 0;
                m_n[d]    = 0;
                m_rd[d]   = 32'h0;
                m_rdk[d]  = 1'b1;
            end
        end else begin
            // registered ports see the array as it was before this edge
            for (int p = 0; p < 2; p++) begin
                m_rd[p]  = mmem[1][addr1[p*2 +: 2]];
                m_rdk[p] = mk[1][addr1[p*2 +: 2]];
            end
            for (int d = 0; d < 2; d++) begin
                if (load_start) begin
                    m_load[d] = 1'b1;
                    m_en[d]   = 1'b0;
                    m_ptr[d]  = 0;
                    m_n[d]    = 0;
                    m_err[d]  = 1'b0;
                end else if (m_load[d] && load_valid) begin
                    m_b[d][m_n[d]] = load_byte;
                    m_n[d]++;
                    if (m_n[d] == 4 || load_last) begin
                        m_w = 32'h0;
                        for (int i = 0; i < m_n[d]; i++)
                            m_w = m_w + (32'(m_b[d][i]) << (8 * i));
                        if (m_ptr[d] < dep(d)) begin
                            mmem[d][m_ptr[d]] = m_w;
                            mk[d][m_ptr[d]]   = 1'b1;
                            m_ptr[d]++;
                        end else begin
                            m_err[d] = 1'b1;
                        end
                        m_n[d] = 0;
                    end
                    if (load_last) begin
                        m_load[d] = 1'b0;
                        m_en[d]   = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("core_en0", 32'(en0), 32'(m_en[0]));
            check("core_en1", 32'(en1), 32'(m_en[1]));
            check("loading0", 32'(ld0), 32'(m_load[0]));
            check("loading1", 32'(ld1), 32'(m_load[1]));
            check("ready0", 32'(rdy0), 32'(m_load[0]));
            check("ready1", 32'(rdy1), 32'(m_load[1]));
            check("count0", 32'(cnt0), 32'(m_ptr[0]));
            check("count1", 32'(cnt1), 32'(m_ptr[1]));
            check("err0", 32'(err0), 32'(m_err[0]));
            check("err1", 32'(err1), 32'(m_err[1]));
            for (int p = 0; p < 2; p++) begin
                if (mk[0][addr0[p*8 +: 8]])
                    check("comb_rd", data0[p*32 +: 32],
                          mmem[0][addr0[p*8 +: 8]]);
                if (m_rdk[p])
                    check("reg_rd", data1[p*32 +: 32], m_rd[p]);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        load_valid = 1'b1;
        load_byte  = b;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic last);
        for (int i = 0; i < 4; i++)
            send(w[i*8 +: 8], last && (i == 3));
    endtask

    task automatic set_addr(input int a, input int b);
        addr0 = {8'(b), 8'(a)};
        addr1 = {2'(b), 2'(a)};
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_byte  = 8'h00;
        addr0      = '0;
        addr1      = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_core_en", 32'(en0), 32'd0);
        check("rst_count", 32'(cnt0), 32'd0);
        check("rst_ready", 32'(rdy0), 32'd0);
        check("rst_regout", data1[31:0], 32'h0);

        // Load A
        start();
        send(8'h13, 1'b0);
        send(8'h01, 1'b0);
        send(8'h20, 1'b0);
        send(8'h00, 1'b1);
        check("a_core_en", 32'(en0), 32'd1);
        check("a_count", 32'(cnt0), 32'd1);
        set_addr(0, 0);
        check("a_port0", data0[31:0], 32'h00200113);
        check("a_port1", data0[63:32], 32'h00200113);
        tick();
        check("a_reg_port1", data1[63:32], 32'h00200113);

        // Partial word
        start();
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        send(8'hCC, 1'b1);
        check("part_word", data0[31:0], 32'h00CCBBAA);
        check("part_count", 32'(cnt0), 32'd1);

        // Restart after 6 bytes
        start();
        for (int i = 0; i < 6; i++)
            send(8'(8'h11 + i), 1'b0);
        check("rs_mid_count", 32'(cnt0), 32'd1);
        start();
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b1);
        check("rs_word", data0[31:0], 32'h04030201);
        check("rs_count", 32'(cnt0), 32'd1);
        check("rs_err", 32'(err0), 32'd0);

        // Overflow on the 4-word instance
        start();
        for (int k = 0; k < 5; k++)
            send_word(32'h13121110 + 32'(k) * 32'h10101010, k == 4);
        check("ov_count1", 32'(cnt1), 32'd4);
        check("ov_err1", 32'(err1), 32'd1);
        check("ov_en1", 32'(en1), 32'd1);
        check("ov_count0", 32'(cnt0), 32'd5);
        for (int k = 0; k < 4; k++) begin
            set_addr(k, k);
            tick();
            check("ov_mem1", data1[31:0], 32'h13121110 + 32'(k) * 32'h10101010);
        end
        set_addr(4, 0);
        check("ov_mem0_w5", data0[31:0], 32'h53525150);
        start();
        check("ov_err_clr", 32'(err1), 32'd0);

        // Reset mid-load
        send_word(32'h0A0B0C0D, 1'b0);
        send_word(32'h1A1B1C1D, 1'b0);
        send(8'hEE, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rm_core_en", 32'(en0), 32'd0);
        check("rm_loading", 32'(ld0), 32'd0);
        check("rm_ready", 32'(rdy0), 32'd0);
        set_addr(0, 1);
        check("rm_mem0", data0[31:0], 32'h0A0B0C0D);
        check("rm_mem1", data0[63:32], 32'h1A1B1C1D);

        // Registered read latency and read-during-write
        set_addr(3, 2);
        check("rg_before", data1[31:0], 32'h0);
        tick();
        check("rg_after3", data1[31:0], 32'h43424140);
        check("rg_after2", data1[63:32], 32'h33323130);
        start();
        send_word(32'h50515253, 1'b0);
        send_word(32'h54555657, 1'b0);
        send_word(32'h58595A5B, 1'b0);
        send_word(32'h77665544, 1'b1);
        check("rw_old", data1[31:0], 32'h43424140);
        tick();
        check("rw_new", data1[31:0], 32'h77665544);
        check("rw_en", 32'(en1), 32'd1);

        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/progmem_multiport.md
Name: progmem_multiport

Overview:
- Parametrised program memory for the multicore processor. It replaces the per-core ad-hoc instruction arrays.
- Serves N_PORTS independent instruction-fetch ports, one per CORE, each with selectable combinational or registered read.
- Adds a byte-serial loader FSM that writes programs into the array and gates the cores' en while a load is in progress.

Parameters:
- INST_W, 32, instruction width in bits; must be a multiple of 8.
- ADDR_W, 8, fetch address width; DEPTH = 2**ADDR_W words.
- N_PORTS, 2, number of fetch ports (cores served).
- REG_OUT, 0, read mode:
  - 0 = combinational read (current CORE timing);
  - 1 = registered read, 1-cycle latency.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- progmem_addr  in  N_PORTS*ADDR_W  fetch addresses; port p occupies bits [p*ADDR_W +: ADDR_W].
- progmem_data  out  N_PORTS*INST_W  fetched instructions; port p occupies bits [p*INST_W +: INST_W].
- core_en  out  1  enable to all cores; low during reset and while loading.
- load_start  in  1  single-cycle pulse: begin or restart a load at word 0.
- load_valid  in  1  load_byte is valid this cycle.
- load_byte  in  8  program byte, little-endian within a word.
- load_last  in  1  qualifies the final byte of the program; sampled with load_valid.
- load_ready  out  1  loader accepts a byte this cycle.
- loading  out  1  loader FSM is in LOAD.
- load_count  out  ADDR_W+1  number of words written by the current or last load.
- load_err  out  1  sticky overflow flag: a write was attempted beyond DEPTH.

Behaviour:
- Reset values: state=IDLE, core_en=0, load_ready=0, loading=0, load_count=0, load_err=0, byte index bi=0.
  - REG_OUT=1 output registers reset to 0.
  - The memory array is NOT cleared by rst; contents survive reset.
- Byte accept: a byte is taken only when load_valid && load_ready. load_ready=1 exactly when state=LOAD.
- FSM IDLE:
  - core_en holds its last value (0 after reset, 1 after a completed load).
  - load_start -> LOAD: wr_ptr=0, bi=0, load_count=0, load_err=0, core_en=0, all on that same edge.
- FSM LOAD:
  - An accepted byte goes to assembly lane bi; bi increments.
  - On the accepted byte with bi = INST_W/8-1, the full word is written to mem[wr_ptr]; then wr_ptr++, load_count++, bi=0.
  - Accepted byte with load_last=1:
    - lanes above bi are zero-filled and the word is written that cycle;
    - then -> IDLE with core_en=1 on the next cycle.
  - load_start in LOAD restarts the load:
    - the partial word is discarded; wr_ptr, bi and load_count are cleared;
    - load_start takes priority over a same-cycle byte.
- Overflow:
  - A word write when wr_ptr == DEPTH is dropped and load_err is set to 1.
  - wr_ptr and load_count saturate at DEPTH.
  - load_last still returns the FSM to IDLE and raises core_en.
  - load_err stays set until the next load_start or rst.
- Reads, REG_OUT=0:
  - progmem_data[p] = mem[progmem_addr[p]] combinationally.
  - A word written at edge t is visible after edge t.
- Reads, REG_OUT=1:
  - progmem_data[p] is registered from the address sampled at edge t and is valid after edge t.
  - Read-during-write to the same address returns the OLD word.
- Port independence: all ports may read the same or different addresses in the same cycle with no stalls or arbitration; reads never block the loader.
- Reset mid-load:
  - -> IDLE, core_en=0; the partial word is lost.
  - Words already written stay in memory.
  - A new load_start is required before core_en rises.

Test Plan:
- Load A (rst, load_start, bytes 13 01 20 00 with last on the 4th byte; N_PORTS=2, REG_OUT=0):
  - mem[0]=0x00200113, load_count=1, core_en=1 one cycle after the last byte.
  - Both ports at addr 0 read 0x00200113 in the same cycle.
- Partial word (3 bytes AA BB CC, last on CC):
  - mem[0]=0x00CCBBAA, load_count=1.
- Restart (load_start after 6 bytes of a load, then 4 bytes 01 02 03 04 with last):
  - mem[0]=0x04030201, load_count=1, load_err=0.
- Overflow (ADDR_W=2; load 5 full words, last on word 5):
  - mem[0..3] hold words 1-4; word 5 is dropped.
  - load_count=4, load_err=1, core_en=1.
  - load_err clears on the next load_start.
- Reset mid-load (rst after 2 full words):
  - core_en=0, loading=0, load_ready=0.
  - mem[0..1] are still readable with the loaded values.
- REG_OUT=1:
  - addr 3 applied at edge t: data appears after edge t, not before.
  - Same-cycle write to addr 3: the old word is returned first, the new word on the next read.
